// File: rtl/eda_neigh_stack.sv
// rtl/eda_neigh_stack.sv - LIFO stack loaded one neighbour address per cycle from an 8-neighbour batch
`ifndef CFG_M
`define CFG_M 8
`endif
`ifndef CFG_N
`define CFG_N 8
`endif
`ifndef CFG_WINDOW_WIDTH
`define CFG_WINDOW_WIDTH 9
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 6
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 3
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 3
`endif

module eda_neigh_stack #(
  parameter int M            = `CFG_M,
  parameter int N            = `CFG_N,
  parameter int WINDOW_WIDTH = `CFG_WINDOW_WIDTH,
  parameter int ADDR_WIDTH   = `CFG_ADDR_WIDTH,
  parameter int I_WIDTH      = `CFG_I_WIDTH,
  parameter int J_WIDTH      = `CFG_J_WIDTH,
  parameter int STACK_DEPTH  = 16
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   clear,
  input  logic                                   push_valid,
  output logic                                   push_ready,
  input  logic [WINDOW_WIDTH-2:0]                push_positions,
  input  logic [(WINDOW_WIDTH-1)*ADDR_WIDTH-1:0] neigh_addr,
  input  logic                                   pop_req,
  output logic                                   pop_valid,
  output logic [ADDR_WIDTH-1:0]                  pop_addr,
  output logic                                   empty,
  output logic                                   full,
  output logic [$clog2(STACK_DEPTH+1)-1:0]       count,
  output logic                                   overflow
);

  localparam int NB = WINDOW_WIDTH - 1;
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  if (I_WIDTH + J_WIDTH != ADDR_WIDTH || M > (1 << I_WIDTH) || N > (1 << J_WIDTH)) begin : g_cfg_check
    $error("eda_neigh_stack: address fields do not cover the image");
  end

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                     state_q, state_d;
  logic [NB-1:0]              mask_q, mask_d;
  logic [NB*ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CW-1:0]              sp_q, sp_d;
  logic [ADDR_WIDTH-1:0]      pop_addr_q, pop_addr_d;
  logic                       pop_valid_q, pop_valid_d;
  logic                       overflow_q, overflow_d;

  logic [ADDR_WIDTH-1:0]      mem [STACK_DEPTH];
  logic                       mem_we;
  logic [IW-1:0]              mem_widx;
  logic [CW-1:0]              sp_m1;
  logic [IW-1:0]              top_idx;
  logic [NB-1:0]              sel_onehot;
  logic [ADDR_WIDTH-1:0]      sel_addr;
  logic                       pop_ok;
  logic                       loading;

  assign empty      = (sp_q == '0);
  assign full       = (sp_q == CW'(STACK_DEPTH));
  assign count      = sp_q;
  assign push_ready = (state_q == IDLE);
  assign pop_valid  = pop_valid_q;
  assign pop_addr   = pop_addr_q;
  assign overflow   = overflow_q;

  assign sp_m1   = sp_q - CW'(1);
  assign top_idx = sp_m1[IW-1:0];
  assign loading = (state_q == LOAD);
  assign pop_ok  = pop_req && !empty;

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    sel_onehot = '0;
    sel_addr   = '0;
    for (int b = 0; b < NB; b++) begin
      if (mask_q[b]) begin
        sel_onehot    = '0;
        sel_onehot[b] = 1'b1;
        sel_addr      = addr_q[b*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    sp_d        = sp_q;
    pop_addr_d  = pop_addr_q;
    pop_valid_d = 1'b0;
    overflow_d  = overflow_q;
    mem_we      = 1'b0;
    mem_widx    = sp_q[IW-1:0];

    case (state_q)
      IDLE: begin
        if (push_valid && (push_positions != '0)) begin
          mask_d  = push_positions;
          addr_d  = neigh_addr;
          state_d = LOAD;
        end
      end
      LOAD: begin
        mask_d = mask_q & ~sel_onehot;
        if (mask_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees the top slot, so the new address replaces it.
    if (loading) begin
      if (pop_ok) begin
        mem_we   = 1'b1;
        mem_widx = top_idx;
      end else if (full) begin
        overflow_d = 1'b1;
      end else begin
        mem_we = 1'b1;
        sp_d   = sp_q + CW'(1);
      end
    end

    if (pop_ok) begin
      pop_addr_d  = mem[top_idx];
      pop_valid_d = 1'b1;
      if (!loading) sp_d = sp_m1;
    end

    if (clear) begin
      state_d     = IDLE;
      mask_d      = '0;
      sp_d        = '0;
      overflow_d  = 1'b0;
      pop_valid_d = 1'b0;
      pop_addr_d  = pop_addr_q;
      mem_we      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      addr_q      <= '0;
      sp_q        <= '0;
      pop_addr_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      sp_q        <= sp_d;
      pop_addr_q  <= pop_addr_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem[mem_widx] <= sel_addr;
  end

endmodule

// File: tb/tb_eda_neigh_stack.sv
// tb/tb_eda_neigh_stack.sv - scoreboard bench for eda_neigh_stack
`timescale 1ns/1ps
module tb_eda_neigh_stack;

  localparam int AW = 6;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset_n, clear, push_valid, pop_req;
  logic          push_ready, pop_valid, empty, full, overflow;
  logic [NB-1:0] push_positions;
  logic [NB*AW-1:0] neigh_addr;
  logic [AW-1:0] pop_addr;
  logic [2:0]    count;

  int nvec = 0;
  int nerr = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] a [NB];

  eda_neigh_stack #(
    .M(8), .N(8), .WINDOW_WIDTH(9), .ADDR_WIDTH(AW),
    .I_WIDTH(3), .J_WIDTH(3), .STACK_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_positions(push_positions), .neigh_addr(neigh_addr),
    .pop_req(pop_req), .pop_valid(pop_valid), .pop_addr(pop_addr),
    .empty(empty), .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Popped data is checked against what the pop request expected to see.
  always @(negedge clk) begin
    if (pop_valid) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
      else chk("pop_addr", {26'd0, pop_addr}, {26'd0, exp_q.pop_front()});
    end
  end

  task automatic push(input logic [NB-1:0] mask);
    for (int b = 0; b < NB; b++) neigh_addr[b*AW +: AW] = a[b];
    push_positions = mask;
    push_valid = 1'b1;
    step();
    push_valid = 1'b0;
    push_positions = '0;
  endtask

  task automatic pop(input logic [AW-1:0] expv);
    exp_q.push_back(expv);
    pop_req = 1'b1;
    step();
    pop_req = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"},    push_ready, 1);
    chk({tag, "_empty"},    empty,      1);
    chk({tag, "_full"},     full,       0);
    chk({tag, "_count"},    count,      0);
    chk({tag, "_overflow"}, overflow,   0);
    chk({tag, "_pvalid"},   pop_valid,  0);
    chk({tag, "_paddr"},    pop_addr,   0);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; push_valid = 1'b0; pop_req = 1'b0;
    push_positions = '0; neigh_addr = '0;
    for (int b = 0; b < NB; b++) a[b] = AW'(6'o40 + b);
    step(); step();
    chk_reset_outs("rst");
    reset_n = 1'b1;
    step();

    // empty mask is accepted and ignored
    push(8'h00);
    chk("zero_mask_ready", push_ready, 1);
    chk("zero_mask_count", count, 0);

    // two-bit batch: upleft then downright
    a[7] = 6'o11; a[0] = 6'o33;
    push(8'b1000_0001);
    chk("b2_ready0", push_ready, 0);
    chk("b2_count0", count, 0);
    step();
    chk("b2_ready1", push_ready, 0);
    chk("b2_count1", count, 1);
    step();
    chk("b2_ready2", push_ready, 1);
    chk("b2_count2", count, 2);
    pop(6'o33);
    chk("b2_pv", pop_valid, 1);
    pop(6'o11);
    chk("b2_empty", empty, 1);
    step();
    chk("b2_pv_pulse", pop_valid, 0);

    // full batch overflows after four entries
    for (int b = 0; b < NB; b++) a[b] = AW'(6'o40 + b);
    push(8'hFF);
    for (int i = 0; i < 8; i++) begin
      chk("ff_ready_low", push_ready, 0);
      step();
    end
    chk("ff_ready_back", push_ready, 1);
    chk("ff_count", count, 4);
    chk("ff_full", full, 1);
    chk("ff_overflow", overflow, 1);
    pop(a[4]); pop(a[5]); pop(a[6]); pop(a[7]);
    chk("ff_empty", empty, 1);

    // pop while empty is ignored
    pop_req = 1'b1;
    step();
    pop_req = 1'b0;
    chk("epop_pv", pop_valid, 0);
    chk("epop_count", count, 0);
    chk("epop_ovf", overflow, 1);
    chk("epop_paddr", pop_addr, a[7]);

    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_ovf", overflow, 0);

    // fill, then a pop coincident with the next LOAD write while full
    push(8'hF0);
    repeat (4) step();
    chk("fill_count", count, 4);
    a[0] = 6'o77;
    push(8'h01);
    exp_q.push_back(a[4]);
    pop_req = 1'b1;
    step();
    pop_req = 1'b0;
    chk("cc_count", count, 4);
    chk("cc_ovf", overflow, 0);
    chk("cc_ready", push_ready, 1);
    pop(6'o77); pop(a[5]); pop(a[6]); pop(a[7]);
    chk("cc_empty", empty, 1);

    // clear on the second LOAD cycle
    push(8'hF0);
    step();
    chk("clr_mid_count1", count, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_mid_count", count, 0);
    chk("clr_mid_ready", push_ready, 1);
    chk("clr_mid_ovf", overflow, 0);
    step(); step();
    chk("clr_mid_stay", count, 0);

    // reset mid-LOAD with three entries, beating clear and pop
    push(8'hF0);
    repeat (3) step();
    chk("rml_count", count, 3);
    chk("rml_ready", push_ready, 0);
    reset_n = 1'b0; clear = 1'b1; pop_req = 1'b1;
    step();
    reset_n = 1'b1; clear = 1'b0; pop_req = 1'b0;
    chk_reset_outs("rml");
    step();
    chk("rml_hold_count", count, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/eda_neigh_stack.md
EDA_NEIGH_STACK -- requirements
Module: eda_neigh_stack

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- M, `CFG_M, image rows
- N, `CFG_N, image columns
- WINDOW_WIDTH, `CFG_WINDOW_WIDTH, window pixels including centre; 8 neighbours = WINDOW_WIDTH-1
- ADDR_WIDTH, `CFG_ADDR_WIDTH, pixel address {i, j}
- I_WIDTH, `CFG_I_WIDTH, row field width
- J_WIDTH, `CFG_J_WIDTH, column field width
- STACK_DEPTH, 16, number of stack entries

REQ-002 Ports SHALL be (name, direction, width, meaning), with clock and reset first:
- clk, in, 1, single clock
- reset_n, in, 1, synchronous active-low reset
- clear, in, 1, synchronous flush
- push_valid, in, 1, neighbour batch offered
- push_ready, out, 1, batch accepted when high together with push_valid
- push_positions, in, WINDOW_WIDTH-1, neighbour mask; bit7=upleft, 6=up, 5=upright, 4=left, 3=right, 2=downleft, 1=down, 0=downright
- neigh_addr, in, (WINDOW_WIDTH-1)*ADDR_WIDTH, packed addresses, same index order as push_positions
- pop_req, in, 1, pop top entry
- pop_valid, out, 1, pop_addr valid (one-cycle pulse)
- pop_addr, out, ADDR_WIDTH, popped {i, j}
- empty, out, 1, count == 0
- full, out, 1, count == STACK_DEPTH
- count, out, $clog2(STACK_DEPTH+1), occupied entries
- overflow, out, 1, sticky: an address was dropped

Function
REQ-003 FSM SHALL have two states, IDLE and LOAD; push_ready = (state == IDLE).
REQ-004 In IDLE, push_valid with a nonzero mask SHALL latch the mask and all addresses and move to LOAD.
REQ-005 In IDLE, push_valid with mask == 0 SHALL be accepted with no effect; the FSM stays in IDLE.
REQ-006 In LOAD, each cycle SHALL write the address of the highest-index remaining set bit to mem[sp], increment sp, and clear that bit.
REQ-007 The cycle that clears the last remaining bit SHALL return the FSM to IDLE; a k-bit mask SHALL keep push_ready low for exactly k cycles.
REQ-008 A LOAD write while full without a concurrent pop SHALL drop the address, clear its bit, and set overflow; sp is unchanged.
REQ-009 pop_req while not empty SHALL, at the next edge, register pop_addr = mem[sp-1], pulse pop_valid for one cycle, and decrement sp.
REQ-010 pop_req while empty SHALL be ignored: pop_valid = 0 and pop_addr holds its value.
REQ-011 A concurrent valid pop and LOAD write SHALL return the old mem[sp-1], write the new address into mem[sp-1], and leave sp unchanged.
REQ-012 The concurrent case in REQ-011 SHALL be legal when full and SHALL NOT set overflow.
REQ-013 Pop and LOAD write while empty SHALL ignore the pop and perform the write.
REQ-014 An address written at edge k SHALL be poppable by a pop_req sampled at edge k+1.
REQ-015 Ordering SHALL be LIFO; within one batch upleft is stored first and downright last.
REQ-016 empty, full, and count SHALL derive combinationally from the sp register only.
REQ-017 clear SHALL set sp=0, FSM=IDLE, overflow=0, pop_valid=0 at the next edge and discard remaining mask bits.
REQ-018 clear SHALL override a simultaneous push and pop; pop_addr SHALL hold.
REQ-019 Memory contents SHALL NOT require reset.

Reset
REQ-020 reset_n low at an edge SHALL force FSM=IDLE, sp=0, pop_addr=0, pop_valid=0, overflow=0.
REQ-021 Resulting reset outputs SHALL be: push_ready=1, empty=1, full=0, count=0.
REQ-022 Reset SHALL take priority over clear and all other inputs, including mid-LOAD.

Verification (M=N=8, ADDR_WIDTH=6, STACK_DEPTH=4)
REQ-023 Mask 8'b1000_0001, upleft=6'o11, downright=6'o33 -> push_ready low 2 cycles, count 1 then 2; two pops return 6'o33 then 6'o11, then empty=1.
REQ-024 Mask 8'hFF from empty -> LOAD 8 cycles; upleft, up, upright, left stored; count=4, full=1, overflow=1; pops return left, upright, up, upleft.
REQ-025 pop_req with count=0 -> pop_valid=0, count=0, overflow unchanged.
REQ-026 Full (count=4), new batch with one bit set, pop_req coincident with the LOAD write -> pop_addr = old top, new address now on top, count=4, overflow=0.
REQ-027 clear asserted on the 2nd LOAD cycle of mask 8'hF0 -> next cycle count=0, push_ready=1, overflow=0; remaining addresses never written.
REQ-028 reset_n low for one edge mid-LOAD with count=3 -> all outputs equal REQ-020/REQ-021 values on the following cycle.
